mips_cpu_exec_unit: RTL and testbench

- Execute stage of the multi-cycle MIPS-I CPU.
- Decodes the 4-bit controller ALU opcode plus the R-type funct field into an ALU function.
- Produces the combinational 32-bit result and the branch condition flag.
- Holds the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- The controller drives alu_op and muldiv_write. Operand A is rs or PC; operand B is rt, an immediate, or 4.

---
 rtl/mips_exec_pkg.sv | 59 +++++
 rtl/mips_exec_decode.sv | 60 ++++++
 rtl/mips_cpu_exec_unit.sv | 125 ++++++++++++
 tb/tb_mips_cpu_exec_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_exec_pkg.sv
// Shared encodings for the MIPS-I execute stage: controller ALU op classes,
// R-type funct codes and the internal ALU / HI-LO operation selectors.
package mips_exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_RTYPE = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_BNE   = 4'd3;
  localparam logic [3:0] OP_BLEZ  = 4'd4;
  localparam logic [3:0] OP_BGTZ  = 4'd5;
  localparam logic [3:0] OP_BLTZ  = 4'd6;
  localparam logic [3:0] OP_BGEZ  = 4'd7;
  localparam logic [3:0] OP_SLTI  = 4'd8;
  localparam logic [3:0] OP_SLTIU = 4'd9;
  localparam logic [3:0] OP_ANDI  = 4'd10;
  localparam logic [3:0] OP_ORI   = 4'd11;
  localparam logic [3:0] OP_XORI  = 4'd12;
  localparam logic [3:0] OP_LUI   = 4'd13;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_PASSA, ALU_MFHI, ALU_MFLO,
    ALU_ZERO, ALU_LUI,
    ALU_BEQ, ALU_BNE, ALU_BLEZ, ALU_BGTZ, ALU_BLTZ, ALU_BGEZ
  } alu_func_t;

  typedef enum logic [2:0] {
    MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
  } muldiv_op_t;

endpackage

// File: rtl/mips_exec_decode.sv
// Maps the controller op class and R-type funct field onto the internal
// ALU function and the HI/LO operation it implies.
module mips_exec_decode
  import mips_exec_pkg::*;
(
  input  logic [3:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_func_o,
  output logic [2:0] muldiv_op_o
);

  always_comb begin
    alu_func_o  = ALU_ADD;
    muldiv_op_o = MD_NONE;
    case (alu_op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SLL:                alu_func_o = ALU_SLL;
          FN_SRL:                alu_func_o = ALU_SRL;
          FN_SRA:                alu_func_o = ALU_SRA;
          FN_SLLV:               alu_func_o = ALU_SLLV;
          FN_SRLV:               alu_func_o = ALU_SRLV;
          FN_SRAV:               alu_func_o = ALU_SRAV;
          FN_JR, FN_JALR:        alu_func_o = ALU_PASSA;
          FN_MFHI:               alu_func_o = ALU_MFHI;
          FN_MFLO:               alu_func_o = ALU_MFLO;
          FN_MTHI: begin alu_func_o = ALU_PASSA; muldiv_op_o = MD_MTHI; end
          FN_MTLO: begin alu_func_o = ALU_PASSA; muldiv_op_o = MD_MTLO; end
          FN_MULT:  begin alu_func_o = ALU_ZERO; muldiv_op_o = MD_MULT;  end
          FN_MULTU: begin alu_func_o = ALU_ZERO; muldiv_op_o = MD_MULTU; end
          FN_DIV:   begin alu_func_o = ALU_ZERO; muldiv_op_o = MD_DIV;   end
          FN_DIVU:  begin alu_func_o = ALU_ZERO; muldiv_op_o = MD_DIVU;  end
          FN_ADD, FN_ADDU:       alu_func_o = ALU_ADD;
          FN_SUB, FN_SUBU:       alu_func_o = ALU_SUB;
          FN_AND:                alu_func_o = ALU_AND;
          FN_OR:                 alu_func_o = ALU_OR;
          FN_XOR:                alu_func_o = ALU_XOR;
          FN_NOR:                alu_func_o = ALU_NOR;
          FN_SLT:                alu_func_o = ALU_SLT;
          FN_SLTU:               alu_func_o = ALU_SLTU;
          default:               alu_func_o = ALU_ADD;
        endcase
      end
      OP_BEQ:   alu_func_o = ALU_BEQ;
      OP_BNE:   alu_func_o = ALU_BNE;
      OP_BLEZ:  alu_func_o = ALU_BLEZ;
      OP_BGTZ:  alu_func_o = ALU_BGTZ;
      OP_BLTZ:  alu_func_o = ALU_BLTZ;
      OP_BGEZ:  alu_func_o = ALU_BGEZ;
      OP_SLTI:  alu_func_o = ALU_SLT;
      OP_SLTIU: alu_func_o = ALU_SLTU;
      OP_ANDI:  alu_func_o = ALU_AND;
      OP_ORI:   alu_func_o = ALU_OR;
      OP_XORI:  alu_func_o = ALU_XOR;
      OP_LUI:   alu_func_o = ALU_LUI;
      default:  alu_func_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_cpu_exec_unit.sv
// Execute stage: combinational ALU result and branch condition, plus the
// architectural HI/LO registers written by multiply, divide and MTHI/MTLO.
module mips_cpu_exec_unit
  import mips_exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic        muldiv_write,
  output logic [31:0] result,
  output logic        condition
);

  logic [4:0]  func_raw;
  logic [2:0]  md_raw;
  alu_func_t   alu_func;
  muldiv_op_t  md_op;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic [31:0] diff;

  mips_exec_decode u_decode (
    .alu_op_i    (alu_op),
    .funct_i     (funct),
    .alu_func_o  (func_raw),
    .muldiv_op_o (md_raw)
  );

  assign alu_func = alu_func_t'(func_raw);
  assign md_op    = muldiv_op_t'(md_raw);
  assign diff     = a - b;

  always_comb begin
    result    = a + b;
    condition = 1'b0;
    case (alu_func)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = diff;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'd0, a < b};
      ALU_SLL:   result = b << shamt;
      ALU_SRL:   result = b >> shamt;
      ALU_SRA:   result = 32'($signed(b) >>> shamt);
      ALU_SLLV:  result = b << a[4:0];
      ALU_SRLV:  result = b >> a[4:0];
      ALU_SRAV:  result = 32'($signed(b) >>> a[4:0]);
      ALU_PASSA: result = a;
      ALU_MFHI:  result = hi_q;
      ALU_MFLO:  result = lo_q;
      ALU_ZERO:  result = 32'd0;
      ALU_LUI:   result = {b[15:0], 16'h0000};
      ALU_BEQ:   begin result = diff; condition = (a == b); end
      ALU_BNE:   begin result = diff; condition = (a != b); end
      ALU_BLEZ:  begin result = diff; condition = ($signed(a) <= 32'sd0); end
      ALU_BGTZ:  begin result = diff; condition = ($signed(a) >  32'sd0); end
      ALU_BLTZ:  begin result = diff; condition = ($signed(a) <  32'sd0); end
      ALU_BGEZ:  begin result = diff; condition = ($signed(a) >= 32'sd0); end
      default:   result = a + b;
    endcase
  end

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_ovf;
  logic        [31:0] sdiv_b, udiv_b;
  logic signed [31:0] sq, sr;
  logic        [31:0] uq, ur;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisors are forced to 1 in the special cases so the dividers never see
  // an undefined operation; the special results are substituted below.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sdiv_b   = (div_zero || div_ovf) ? 32'd1 : b;
  assign udiv_b   = div_zero ? 32'd1 : b;
  assign sq       = $signed(a) / $signed(sdiv_b);
  assign sr       = $signed(a) % $signed(sdiv_b);
  assign uq       = a / udiv_b;
  assign ur       = a % udiv_b;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (muldiv_write) begin
      case (md_op)
        MD_MULT:  {hi_d, lo_d} = prod_s;
        MD_MULTU: {hi_d, lo_d} = prod_u;
        MD_DIV: begin
          if (div_zero)     begin lo_d = 32'hFFFF_FFFF; hi_d = a;     end
          else if (div_ovf) begin lo_d = 32'h8000_0000; hi_d = 32'd0; end
          else              begin lo_d = sq;            hi_d = sr;    end
        end
        MD_DIVU: begin
          if (div_zero) begin lo_d = 32'hFFFF_FFFF; hi_d = a;  end
          else          begin lo_d = uq;            hi_d = ur; end
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_exec_unit.sv
// Self-checking bench for mips_cpu_exec_unit: directed cases with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_mips_cpu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        muldiv_write = 1'b0;
  logic [31:0] result;
  logic        condition;

  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] exp_r;
  logic        exp_c;

  always #5 clk = ~clk;

  mips_cpu_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_op       (alu_op),
    .funct        (funct),
    .a            (a),
    .b            (b),
    .shamt        (shamt),
    .muldiv_write (muldiv_write),
    .result       (result),
    .condition    (condition)
  );

  function automatic logic [31:0] m_res(input logic [3:0] op, input logic [5:0] f,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [4:0] sh, input logic [31:0] hi,
                                        input logic [31:0] lo);
    int sx, sy;
    logic signed [31:0] ys;
    sx = x; sy = y; ys = y;
    case (op)
      4'd1: begin
        case (f)
          6'h00: return y << sh;
          6'h02: return y >> sh;
          6'h03: return ys >>> sh;
          6'h04: return y << x[4:0];
          6'h06: return y >> x[4:0];
          6'h07: return ys >>> x[4:0];
          6'h08, 6'h09, 6'h11, 6'h13: return x;
          6'h10: return hi;
          6'h12: return lo;
          6'h18, 6'h19, 6'h1A, 6'h1B: return 32'd0;
          6'h20, 6'h21: return x + y;
          6'h22, 6'h23: return x - y;
          6'h24: return x & y;
          6'h25: return x | y;
          6'h26: return x ^ y;
          6'h27: return ~(x | y);
          6'h2A: return (sx < sy) ? 32'd1 : 32'd0;
          6'h2B: return (x < y) ? 32'd1 : 32'd0;
          default: return x + y;
        endcase
      end
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: return x - y;
      4'd8:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd10: return x & y;
      4'd11: return x | y;
      4'd12: return x ^ y;
      4'd13: return {y[15:0], 16'h0000};
      default: return x + y;
    endcase
  endfunction

  function automatic logic m_cond(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx;
    sx = x;
    case (op)
      4'd2: return x == y;
      4'd3: return x != y;
      4'd4: return sx <= 0;
      4'd5: return sx > 0;
      4'd6: return sx < 0;
      4'd7: return sx >= 0;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {hi, lo} after one clock edge with the write strobe asserted.
  function automatic logic [63:0] m_hilo(input logic [5:0] f, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] hi,
                                         input logic [31:0] lo);
    int sx, sy;
    longint p;
    longint unsigned pu;
    sx = x; sy = y;
    case (f)
      6'h18: begin p = longint'(sx) * longint'(sy); return p; end
      6'h19: begin pu = longint'({32'd0, x}) * longint'({32'd0, y}); return pu; end
      6'h1A: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      6'h1B: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      6'h11: return {x, lo};
      6'h13: return {hi, x};
      default: return {hi, lo};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
    end else if (muldiv_write && alu_op == 4'd1) begin
      {m_hi, m_lo} <= m_hilo(funct, a, b, m_hi, m_lo);
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      exp_r = m_res(alu_op, funct, a, b, shamt, m_hi, m_lo);
      exp_c = m_cond(alu_op, a, b);
      n_chk++;
      if (result !== exp_r) begin
        n_err++;
        $display("FAIL model_result op=%0d funct=%h a=%h b=%h sh=%0d: got %h expected %h",
                 alu_op, funct, a, b, shamt, result, exp_r);
      end
      n_chk++;
      if (condition !== exp_c) begin
        n_err++;
        $display("FAIL model_cond op=%0d a=%h b=%h: got %b expected %b",
                 alu_op, a, b, condition, exp_c);
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] op, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh,
                       input logic mw);
    @(negedge clk);
    reset = rst; alu_op = op; funct = f; a = x; b = y; shamt = sh; muldiv_write = mw;
    #3;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fn_list [0:26] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h3F};

  initial begin
    drive(1'b0, 4'd0, 6'h00, 32'd1, 32'd2, 5'd0, 1'b0);
    chk_en = 1'b1;
    drive(1'b0, 4'd0, 6'h00, 32'd3, 32'd4, 5'd0, 1'b1);

    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("reset_hi", result, 32'd0);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("reset_lo", result, 32'd0);

    drive(1'b1, 4'd1, 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
    lit("addu_wrap", result, 32'h8000_0000);
    lit("addu_cond", {31'd0, condition}, 32'd0);
    drive(1'b1, 4'd1, 6'h23, 32'd0, 32'd1, 5'd0, 1'b0);
    lit("subu", result, 32'hFFFF_FFFF);
    drive(1'b1, 4'd1, 6'h03, 32'd0, 32'h8000_0010, 5'd4, 1'b0);
    lit("sra", result, 32'hF800_0001);
    drive(1'b1, 4'd1, 6'h04, 32'h24, 32'd1, 5'd0, 1'b0);
    lit("sllv", result, 32'h0000_0010);
    drive(1'b1, 4'd1, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    lit("slt", result, 32'd1);
    drive(1'b1, 4'd1, 6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
    lit("sltu", result, 32'd0);
    drive(1'b1, 4'd4, 6'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("blez_zero", {31'd0, condition}, 32'd1);
    drive(1'b1, 4'd5, 6'h00, 32'h8000_0000, 32'd0, 5'd0, 1'b0);
    lit("bgtz_neg", {31'd0, condition}, 32'd0);
    drive(1'b1, 4'd13, 6'h00, 32'd0, 32'h0001_ABCD, 5'd0, 1'b0);
    lit("lui", result, 32'hABCD_0000);

    drive(1'b1, 4'd1, 6'h18, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
    lit("mult_result", result, 32'd0);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("mult_hi", result, 32'hFFFF_FFFF);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("mult_lo", result, 32'hFFFF_FFFA);

    drive(1'b1, 4'd1, 6'h1A, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("div_lo", result, 32'hFFFF_FFFD);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("div_hi", result, 32'hFFFF_FFFF);

    drive(1'b1, 4'd1, 6'h1B, 32'd5, 32'd0, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("divu0_lo", result, 32'hFFFF_FFFF);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("divu0_hi", result, 32'd5);

    drive(1'b1, 4'd1, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("divovf_lo", result, 32'h8000_0000);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("divovf_hi", result, 32'd0);

    drive(1'b1, 4'd1, 6'h11, 32'h1234, 32'd0, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("mthi", result, 32'h1234);
    drive(1'b0, 4'd1, 6'h13, 32'h55, 32'd0, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("reset_clears_hi", result, 32'd0);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("reset_beats_write", result, 32'd0);

    drive(1'b1, 4'd1, 6'h13, 32'hABCD, 32'd0, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h11, 32'h1111, 32'd0, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h18, 32'd5, 32'd5, 5'd0, 1'b0);
    drive(1'b1, 4'd0, 6'h18, 32'd7, 32'd7, 5'd0, 1'b1);
    drive(1'b1, 4'd1, 6'h12, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("hold_lo", result, 32'hABCD);
    drive(1'b1, 4'd1, 6'h10, 32'd0, 32'd0, 5'd0, 1'b0);
    lit("hold_hi", result, 32'h1111);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      logic [5:0] f;
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd1;
      f  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 26)];
      drive(($urandom_range(0, 59) != 0), op, f, pick_operand(), pick_operand(),
            5'($urandom), 1'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
